// File: rtl/aes_pkg.sv
// Shared definitions for the AES sequencing controller.
//   state_e      : controller FSM states
//   NBYTES       : bytes per key/block transfer (AES-128)
//   CORE_LAT_DEF : default core latency in cycles
//   AES_ENC/DEC  : blk_mode encodings
package aes_pkg;
  localparam int   NBYTES       = 16;
  localparam int   CORE_LAT_DEF = 13;
  localparam logic AES_ENC      = 1'b0;
  localparam logic AES_DEC      = 1'b1;

  typedef enum logic [2:0] {
    IDLE, KEY, LOAD, START, WAIT, UNLOAD, DONE
  } state_e;
endpackage

// File: rtl/aes_byte_ser.sv
// 128-bit byte serializer / deserializer.
//   load_i/data_i      : parallel load
//   shift_out_i        : shift right one byte (byte 0 leaves first)
//   shift_in_i/idx_i   : write byte_i into slot idx_i
//   data_o             : register contents
//   next_o             : byte 1, i.e. byte 0 after the next shift-out
module aes_byte_ser #(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [NBYTES*8-1:0]   data_i,
  input  logic                  shift_out_i,
  input  logic                  shift_in_i,
  input  logic [3:0]            idx_i,
  input  logic [7:0]            byte_i,
  output logic [NBYTES*8-1:0]   data_o,
  output logic [7:0]            next_o
);
  logic [NBYTES*8-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst)              sr_q <= '0;
    else if (load_i)      sr_q <= data_i;
    else if (shift_out_i) sr_q <= {8'h00, sr_q[NBYTES*8-1:8]};
    else if (shift_in_i)  sr_q[{idx_i, 3'b000} +: 8] <= byte_i;
  end

  assign data_o = sr_q;
  assign next_o = sr_q[15:8];
endmodule

// File: rtl/aes_seq_ctrl.sv
// Sequencer for a byte-serial AES core.
//   key_valid/key_ready/key_in          : key-load handshake
//   blk_valid/blk_ready/blk_mode/blk_in : block request (mode 0 enc, 1 dec)
//   res_valid/res_ready/res_out         : result handshake
//   key_loaded, busy                    : status
//   core_*                              : byte-serial core strobes and data
module aes_seq_ctrl #(
  parameter int CORE_LAT = aes_pkg::CORE_LAT_DEF,
  parameter int NBYTES   = aes_pkg::NBYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [NBYTES*8-1:0] key_in,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic                blk_mode,
  input  logic [NBYTES*8-1:0] blk_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NBYTES*8-1:0] res_out,
  output logic                key_loaded,
  output logic                busy,
  output logic                core_loadkey,
  output logic                core_load_shift,
  output logic                core_staenc,
  output logic                core_stadec,
  output logic [7:0]          core_din,
  input  logic [7:0]          core_dout
);
  import aes_pkg::*;

  localparam int             W         = NBYTES * 8;
  localparam int             WW        = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(CORE_LAT - 1);
  localparam logic [3:0]     BYTE_LAST = 4'(NBYTES - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [WW-1:0] wcnt_q;
  logic          mode_q, key_loaded_q, key_ready_q, blk_ready_q, res_valid_q;
  logic [W-1:0]  res_q;
  logic          loadkey_q, lshift_q, staenc_q, stadec_q;
  logic [7:0]    din_q;

  logic          key_hs, blk_hs, blk_pref;
  logic          ser_load, ser_shift_out, ser_shift_in;
  logic [W-1:0]  ser_din, ser_data, res_fill;
  logic [7:0]    ser_next;

  always_comb begin
    key_hs        = (state_q == IDLE) && key_valid && key_ready_q;
    blk_hs        = (state_q == IDLE) && blk_valid && blk_ready_q && !key_hs;
    // Readiness is offered one side at a time: a pending key always wins,
    // so blk_ready is only raised when no key request is being presented.
    blk_pref      = blk_valid && !key_valid;
    ser_load      = key_hs || blk_hs;
    ser_din       = key_hs ? key_in : blk_in;
    ser_shift_out = (state_q == KEY) || (state_q == LOAD);
    ser_shift_in  = (state_q == UNLOAD);
    // Last unload byte goes straight into the result register.
    res_fill          = ser_data;
    res_fill[W-1 -: 8] = core_dout;
  end

  aes_byte_ser #(.NBYTES(NBYTES)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .data_i     (ser_din),
    .shift_out_i(ser_shift_out),
    .shift_in_i (ser_shift_in),
    .idx_i      (cnt_q),
    .byte_i     (core_dout),
    .data_o     (ser_data),
    .next_o     (ser_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      mode_q       <= AES_ENC;
      key_loaded_q <= 1'b0;
      key_ready_q  <= 1'b0;
      blk_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_q        <= '0;
      loadkey_q    <= 1'b0;
      lshift_q     <= 1'b0;
      staenc_q     <= 1'b0;
      stadec_q     <= 1'b0;
      din_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_hs) begin
            state_q     <= KEY;
            cnt_q       <= '0;
            key_ready_q <= 1'b0;
            blk_ready_q <= 1'b0;
            loadkey_q   <= 1'b1;
            din_q       <= key_in[7:0];
          end else if (blk_hs) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            mode_q      <= blk_mode;
            key_ready_q <= 1'b0;
            blk_ready_q <= 1'b0;
            lshift_q    <= 1'b1;
            din_q       <= blk_in[7:0];
          end else begin
            key_ready_q <= !(blk_pref && key_loaded_q);
            blk_ready_q <= blk_pref && key_loaded_q;
          end
        end
        KEY: begin
          if (cnt_q == BYTE_LAST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            loadkey_q    <= 1'b0;
            din_q        <= '0;
            key_loaded_q <= 1'b1;
            key_ready_q  <= !blk_pref;
            blk_ready_q  <= blk_pref;
          end else begin
            cnt_q <= cnt_q + 4'd1;
            din_q <= ser_next;
          end
        end
        LOAD: begin
          if (cnt_q == BYTE_LAST) begin
            state_q  <= START;
            cnt_q    <= '0;
            lshift_q <= 1'b0;
            din_q    <= '0;
            staenc_q <= (mode_q == AES_ENC);
            stadec_q <= (mode_q == AES_DEC);
          end else begin
            cnt_q <= cnt_q + 4'd1;
            din_q <= ser_next;
          end
        end
        START: begin
          state_q  <= WAIT;
          wcnt_q   <= '0;
          staenc_q <= 1'b0;
          stadec_q <= 1'b0;
        end
        WAIT: begin
          if (wcnt_q == WAIT_LAST) begin
            state_q  <= UNLOAD;
            wcnt_q   <= '0;
            cnt_q    <= '0;
            lshift_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end
        UNLOAD: begin
          if (cnt_q == BYTE_LAST) begin
            state_q     <= DONE;
            cnt_q       <= '0;
            lshift_q    <= 1'b0;
            res_q       <= res_fill;
            res_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            key_ready_q <= !(blk_pref && key_loaded_q);
            blk_ready_q <= blk_pref && key_loaded_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready       = key_ready_q;
  assign blk_ready       = blk_ready_q;
  assign res_valid       = res_valid_q;
  assign res_out         = res_q;
  assign key_loaded      = key_loaded_q;
  assign busy            = (state_q != IDLE);
  assign core_loadkey    = loadkey_q;
  assign core_load_shift = lshift_q;
  assign core_staenc     = staenc_q;
  assign core_stadec     = stadec_q;
  assign core_din        = din_q;
endmodule

// File: tb/tb_aes_seq_ctrl.sv
module tb_aes_seq_ctrl;
  localparam int LAT = 13;
  localparam int NB  = 16;
  localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KAT_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KAT_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0, rst = 1'b1;
  logic key_valid = 0, key_ready, blk_valid = 0, blk_ready, blk_mode = 0;
  logic [127:0] key_in = '0, blk_in = '0, res_out;
  logic res_valid, res_ready = 0, key_loaded, busy;
  logic core_loadkey, core_load_shift, core_staenc, core_stadec;
  logic [7:0] core_din, core_dout;

  always #5 clk = ~clk;

  aes_seq_ctrl #(.CORE_LAT(LAT), .NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_mode(blk_mode), .blk_in(blk_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .key_loaded(key_loaded), .busy(busy),
    .core_loadkey(core_loadkey), .core_load_shift(core_load_shift),
    .core_staenc(core_staenc), .core_stadec(core_stadec),
    .core_din(core_din), .core_dout(core_dout)
  );

  // Stand-in core transform: exact AES answers for the known-answer vectors,
  // an invertible rotate/xor for everything else.
  function automatic logic [127:0] xf_enc(input logic [127:0] b, input logic [127:0] k);
    if (k == KAT_KEY && b == KAT_PT) return KAT_CT;
    return {b[119:0], b[127:120]} ^ k;
  endfunction
  function automatic logic [127:0] xf_dec(input logic [127:0] b, input logic [127:0] k);
    logic [127:0] t;
    if (k == KAT_KEY && b == KAT_CT) return KAT_PT;
    t = b ^ k;
    return {t[7:0], t[127:8]};
  endfunction
  function automatic logic [127:0] model(input logic [127:0] b, input logic m, input logic [127:0] k);
    return m ? xf_dec(b, k) : xf_enc(b, k);
  endfunction

  // Byte-serial core model
  logic [127:0] core_key = '0, core_reg = '0;
  always @(posedge clk) begin
    if (core_loadkey)    core_key <= {core_din, core_key[127:8]};
    if (core_staenc)     core_reg <= xf_enc(core_reg, core_key);
    else if (core_stadec) core_reg <= xf_dec(core_reg, core_key);
    else if (core_load_shift) core_reg <= {core_din, core_reg[127:8]};
  end
  assign core_dout = core_reg[7:0];

  // Bus monitor, sampled mid-cycle
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_checks = 0, n_pass = 0;
  int key_hs_n, blk_hs_n, key_hs_cyc, blk_hs_cyc, n_enc, n_dec, start_cyc, unload_cyc, viol;
  bit started;
  logic [7:0] kq[$], lq[$];
  logic [127:0] cur_key;

  always @(negedge clk) if (!rst) begin
    if (key_valid && key_ready) begin key_hs_n++; key_hs_cyc = cyc; end
    if (blk_valid && blk_ready) begin blk_hs_n++; blk_hs_cyc = cyc; end
    if (core_loadkey) kq.push_back(core_din);
    if (core_load_shift && !started) lq.push_back(core_din);
    if (core_load_shift && started) begin
      if (unload_cyc < 0) unload_cyc = cyc;
      if (core_din !== 8'h00) viol++;
    end
    if (core_staenc) n_enc++;
    if (core_stadec) n_dec++;
    if (core_staenc || core_stadec) begin started = 1; start_cyc = cyc; end
    if (core_staenc && core_stadec) viol++;
    if ((!busy || res_valid) &&
        (core_loadkey || core_load_shift || core_staenc || core_stadec || core_din !== 8'h00)) viol++;
    if (busy && (key_ready || blk_ready)) viol++;
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clr_mon();
    kq.delete(); lq.delete();
    key_hs_n = 0; blk_hs_n = 0; n_enc = 0; n_dec = 0; viol = 0;
    started = 0; start_cyc = -1; unload_cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1; key_valid = 0; blk_valid = 0; res_ready = 0;
    tick();
    n_checks++; if (key_ready !== 1'b0) $display("FAIL rst_key_ready got %b exp 0", key_ready); else n_pass++;
    n_checks++; if (blk_ready !== 1'b0) $display("FAIL rst_blk_ready got %b exp 0", blk_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (key_loaded !== 1'b0) $display("FAIL rst_key_loaded got %b exp 0", key_loaded); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b exp 0", res_valid); else n_pass++;
    n_checks++; if (res_out !== 128'h0) $display("FAIL rst_res_out got %h exp 0", res_out); else n_pass++;
    n_checks++; if ({core_loadkey, core_load_shift, core_staenc, core_stadec} !== 4'b0)
      $display("FAIL rst_strobes got %b exp 0000", {core_loadkey, core_load_shift, core_staenc, core_stadec}); else n_pass++;
    n_checks++; if (core_din !== 8'h00) $display("FAIL rst_core_din got %h exp 00", core_din); else n_pass++;
    rst = 0;
  endtask

  // Block request with no key resident: must never be accepted
  task automatic test_no_key(input int ncyc);
    int rdy;
    clr_mon(); rdy = 0;
    blk_in = KAT_PT; blk_mode = 0; blk_valid = 1;
    for (int i = 0; i < ncyc; i++) begin @(negedge clk); if (blk_ready) rdy++; end
    tick(); blk_valid = 0;
    n_checks++; if (rdy !== 0) $display("FAIL nokey_blk_ready high %0d cycles exp 0", rdy); else n_pass++;
    n_checks++; if (n_enc + n_dec + lq.size() + viol !== 0)
      $display("FAIL nokey_core_activity got %0d exp 0", n_enc + n_dec + lq.size() + viol); else n_pass++;
  endtask

  task automatic load_key(input logic [127:0] k);
    bit hs; logic [127:0] got;
    clr_mon(); key_in = k; key_valid = 1; hs = 0;
    for (int i = 0; i < 60 && !hs; i++) begin @(negedge clk); hs = key_ready; tick(); end
    key_valid = 0;
    n_checks++; if (hs !== 1'b1) $display("FAIL key_handshake timeout got %b exp 1", hs); else n_pass++;
    repeat (NB + 2) tick();
    got = '0;
    for (int i = 0; i < kq.size() && i < NB; i++) got[i*8 +: 8] = kq[i];
    n_checks++; if (kq.size() !== NB) $display("FAIL key_loadkey_cycles got %0d exp %0d", kq.size(), NB); else n_pass++;
    n_checks++; if (got !== k) $display("FAIL key_din_bytes got %h exp %h", got, k); else n_pass++;
    n_checks++; if (key_loaded !== 1'b1 || viol !== 0)
      $display("FAIL key_loaded got %b viol %0d exp 1/0", key_loaded, viol); else n_pass++;
    cur_key = k;
  endtask

  task automatic issue_block(input logic [127:0] b, input logic m);
    bit hs;
    clr_mon(); blk_in = b; blk_mode = m; blk_valid = 1; hs = 0;
    for (int i = 0; i < 60 && !hs; i++) begin @(negedge clk); hs = blk_ready; tick(); end
    blk_valid = 0; blk_mode = $urandom_range(1); blk_in = {$urandom, $urandom, $urandom, $urandom};
    n_checks++; if (hs !== 1'b1) $display("FAIL blk_handshake timeout got %b exp 1", hs); else n_pass++;
  endtask

  task automatic finish_block(input logic [127:0] b, input logic m, input logic [127:0] exp,
                              input int delay, input string nm);
    bit found; int bad; logic [127:0] r0, got;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin @(negedge clk); found = res_valid; end
    n_checks++; if (found !== 1'b1) $display("FAIL %s res_valid timeout got %b exp 1", nm, found); else n_pass++;
    r0 = res_out; bad = 0;
    for (int i = 0; i < delay; i++) begin @(negedge clk); if (res_out !== r0 || res_valid !== 1'b1) bad++; end
    tick(); res_ready = 1;
    tick(); res_ready = 0;
    got = '0;
    for (int i = 0; i < lq.size() && i < NB; i++) got[i*8 +: 8] = lq[i];
    n_checks++; if (r0 !== exp) $display("FAIL %s res_out got %h exp %h", nm, r0, exp); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL %s done_hold unstable %0d cycles exp 0", nm, bad); else n_pass++;
    n_checks++; if (got !== b || lq.size() !== NB)
      $display("FAIL %s load_bytes got %h (%0d) exp %h (%0d)", nm, got, lq.size(), b, NB); else n_pass++;
    n_checks++; if (n_enc !== int'(!m) || n_dec !== int'(m))
      $display("FAIL %s start_pulses enc %0d dec %0d exp %0d/%0d", nm, n_enc, n_dec, int'(!m), int'(m)); else n_pass++;
    n_checks++; if (unload_cyc - start_cyc - 1 !== LAT)
      $display("FAIL %s wait_cycles got %0d exp %0d", nm, unload_cyc - start_cyc - 1, LAT); else n_pass++;
    n_checks++; if (viol !== 0 || res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s protocol viol %0d res_valid %b busy %b exp 0/0/0", nm, viol, res_valid, busy); else n_pass++;
  endtask

  task automatic test_kat();
    issue_block(KAT_PT, 1'b0); finish_block(KAT_PT, 1'b0, KAT_CT, 2, "kat_enc");
    issue_block(KAT_CT, 1'b1); finish_block(KAT_CT, 1'b1, KAT_PT, 0, "kat_dec");
  endtask

  task automatic test_random();
    logic [127:0] b; logic m;
    for (int n = 0; n < 6; n++) begin
      b = {$urandom, $urandom, $urandom, $urandom}; m = $urandom_range(1);
      issue_block(b, m);
      finish_block(b, m, model(b, m, cur_key), $urandom_range(5), "random");
    end
  endtask

  // Key and block presented together: key first, block on the next IDLE cycle
  task automatic test_key_blk_same();
    logic [127:0] k, b; bit kf, bf;
    k = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
    clr_mon(); key_in = k; blk_in = b; blk_mode = 0; key_valid = 1; blk_valid = 1;
    for (int i = 0; i < 100 && (key_valid || blk_valid); i++) begin
      @(negedge clk); kf = key_valid && key_ready; bf = blk_valid && blk_ready;
      tick(); if (kf) key_valid = 0; if (bf) blk_valid = 0;
    end
    key_valid = 0; blk_valid = 0;
    n_checks++; if (key_hs_n !== 1 || blk_hs_n !== 1 || blk_hs_cyc - key_hs_cyc !== NB + 1)
      $display("FAIL same_cycle_order key %0d blk %0d gap %0d exp 1/1/%0d", key_hs_n, blk_hs_n, blk_hs_cyc - key_hs_cyc, NB + 1);
    else n_pass++;
    cur_key = k;
    finish_block(b, 1'b0, model(b, 1'b0, k), 1, "same_cycle");
  endtask

  // Key request during a block is held off and does not disturb the block
  task automatic test_key_while_busy();
    logic [127:0] k, b; logic m;
    k = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
    m = $urandom_range(1);
    issue_block(b, m);
    key_in = k; key_valid = 1;
    finish_block(b, m, model(b, m, cur_key), 3, "busy_key");
    n_checks++; if (key_hs_n !== 0) $display("FAIL busy_key_accepted got %0d exp 0", key_hs_n); else n_pass++;
    load_key(k);
    b = {$urandom, $urandom, $urandom, $urandom};
    issue_block(b, 1'b0); finish_block(b, 1'b0, model(b, 1'b0, k), 0, "new_key");
  endtask

  // Reset in the 5th WAIT cycle, then a fresh key and a slow result consumer
  task automatic test_reset_mid();
    bit seen;
    issue_block(KAT_PT, 1'b0);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); seen = core_staenc || core_stadec; end
    n_checks++; if (seen !== 1'b1) $display("FAIL midrst_start timeout got %b exp 1", seen); else n_pass++;
    repeat (5) tick();
    rst = 1; tick();
    n_checks++; if ({busy, key_loaded, res_valid, key_ready, blk_ready} !== 5'b0 || res_out !== 128'h0)
      $display("FAIL midrst_outputs got %b res %h exp 0", {busy, key_loaded, res_valid, key_ready, blk_ready}, res_out); else n_pass++;
    n_checks++; if ({core_loadkey, core_load_shift, core_staenc, core_stadec} !== 4'b0 || core_din !== 8'h00)
      $display("FAIL midrst_core got %b din %h exp 0", {core_loadkey, core_load_shift, core_staenc, core_stadec}, core_din); else n_pass++;
    rst = 0;
    test_no_key(20);
    load_key(KAT_KEY);
    issue_block(KAT_PT, 1'b0); finish_block(KAT_PT, 1'b0, KAT_CT, 10, "midrst_enc");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    cur_key = '0;
    repeat (2) tick();
    test_reset();
    test_no_key(50);
    load_key(KAT_KEY);
    test_kat();
    test_random();
    test_key_blk_same();
    test_key_while_busy();
    test_reset_mid();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aes_seq_ctrl.md
AES_SEQ_CTRL -- requirements
Module: aes_seq_ctrl

Interface
REQ-001 Parameter CORE_LAT, default 13, SHALL set the wait cycles between the start-pulse cycle and the first unload cycle.
REQ-002 Parameter NBYTES, default 16, SHALL set the bytes per key/block transfer (fixed 16 for AES-128).
REQ-003 clk  input  1  SHALL be the single clock; all logic rising-edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 key_valid, key_ready  in/out  1/1  SHALL form the key-load handshake.
REQ-006 key_in  input  128  SHALL carry the cipher key; byte 0 = key_in[7:0].
REQ-007 blk_valid, blk_ready  in/out  1/1  SHALL form the block-request handshake.
REQ-008 blk_mode  input  1  SHALL select the operation: 0 encrypt, 1 decrypt; sampled with blk_in.
REQ-009 blk_in  input  128  SHALL carry the plain text or cipher text; byte 0 = blk_in[7:0].
REQ-010 res_valid, res_ready  out/in  1/1  SHALL form the result handshake.
REQ-011 res_out  output  128  SHALL carry the result; byte 0 = res_out[7:0].
REQ-012 key_loaded, busy  output  1/1  SHALL indicate a key is resident in the core, and the FSM is not IDLE.
REQ-013 core_loadkey, core_load_shift, core_staenc, core_stadec  output  1 each  SHALL drive the core strobes.
REQ-014 core_din  output  8  SHALL be the byte to the core; core_dout  input  8  SHALL be the byte from the core.

Function
REQ-015 FSM states SHALL be IDLE, KEY, LOAD, START, WAIT, UNLOAD, DONE.
REQ-016 Handshakes SHALL complete on a cycle with valid and ready both high; ready is registered and high only in IDLE.
REQ-017 In IDLE, blk_ready SHALL be low while key_loaded=0; a key request SHALL win over a block request presented in the same cycle.
REQ-018 KEY SHALL last exactly NBYTES cycles: core_loadkey=1, core_din=key byte i in cycle i, ascending from byte 0; then key_loaded<=1, go to IDLE.
REQ-019 LOAD SHALL last NBYTES cycles: core_load_shift=1, core_din=block byte i in cycle i, ascending; then go to START.
REQ-020 START SHALL last 1 cycle: core_staenc=1 if mode=0, else core_stadec=1; never both.
REQ-021 WAIT SHALL last CORE_LAT cycles with all strobes low, then go to UNLOAD.
REQ-022 UNLOAD SHALL last NBYTES cycles: core_load_shift=1, core_din=0; core_dout sampled at the end of cycle i SHALL become res_out byte i.
REQ-023 DONE SHALL hold res_valid=1 and res_out stable until res_ready, then return to IDLE.
REQ-024 A 4-bit byte counter and a wait counter sized for CORE_LAT SHALL be used; each SHALL clear on state entry with no wrap-around past its terminal count.
REQ-025 core_din SHALL be 0 and all core strobes 0 in IDLE, WAIT and DONE.
REQ-026 A key_valid arriving while busy SHALL be held off (key_ready=0) until IDLE; it SHALL never corrupt an in-flight block.

Reset
REQ-027 rst SHALL take priority over every other input, mid-operation included: FSM to IDLE, counters 0, key_loaded=0, res_valid=0, res_out=0, all core strobes 0, core_din=0, key_ready=blk_ready=0 in the reset cycle.
REQ-028 After reset, a new key load SHALL be required before any block is accepted.

Structure
REQ-029 A shared aes_pkg SHALL hold the state enum, NBYTES, the mode encodings (AES_ENC=0, AES_DEC=1) and the CORE_LAT default.
REQ-030 One sub-module SHALL be used: aes_byte_ser, a 128-bit shift register with selectable shift-out (byte 0 first) or shift-in (byte i into slot i); it SHALL be used for both load and unload.

Verification
REQ-031 Key load: key_in=2b7e151628aed2a6abf7158809cf4f3c -> 16 loadkey cycles with core_din 3c,4f,cf,09 ... 7e,2b; key_loaded=1.
REQ-032 Encrypt, core attached: blk_in=3243f6a8885a308d313198a2e0370734, mode 0 -> staenc pulsed once, exactly 13 wait cycles, res_out=3925841d02dc09fbdc118597196a0b32.
REQ-033 Decrypt: blk_in=3925841d02dc09fbdc118597196a0b32, mode 1 -> stadec pulse, res_out=3243f6a8885a308d313198a2e0370734.
REQ-034 Block request before any key -> blk_ready stays 0 for 50 cycles, no core strobes.
REQ-035 key_valid and blk_valid high together in IDLE -> key accepted first, block accepted next IDLE cycle.
REQ-036 rst pulsed in the 5th WAIT cycle, then res_ready held 0 for 10 cycles in DONE -> outputs at reset values, key_loaded=0; in DONE, res_out stable and res_valid=1 throughout.
